// File: rtl/i2s_master_trx_if.sv
// ---------------------------------------------------------------------------
// i2s_master_trx_if
// Word-side bus of the I2S master transceiver: the stereo transmit pair with
// its handshake and the stereo receive pair with its strobe.
//
// Ports / signals:
//   tx_left, tx_right  stereo word pair to transmit (data_width bits each)
//   tx_valid           client presents a pair
//   tx_ready           transceiver holding register is empty
//   rx_left, rx_right  last received stereo pair
//   rx_valid           one-clk strobe, new pair on rx_left/rx_right
//
// Handshake: a pair transfers on every clk edge where tx_valid and tx_ready
// are both high; tx_left/tx_right only matter in that cycle, tx_valid may be
// withdrawn at any time, and tx_ready never depends on tx_valid. rx_valid
// has no backpressure.
//
// Modports: master = the transceiver, slave = the word-side client.
// ---------------------------------------------------------------------------
interface i2s_master_trx_if #(
   parameter int data_width = 24
);
   logic [data_width-1:0] tx_left;
   logic [data_width-1:0] tx_right;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [data_width-1:0] rx_left;
   logic [data_width-1:0] rx_right;
   logic                  rx_valid;

   modport master (
      input  tx_left,
      input  tx_right,
      input  tx_valid,
      output tx_ready,
      output rx_left,
      output rx_right,
      output rx_valid
   );

   modport slave (
      output tx_left,
      output tx_right,
      output tx_valid,
      input  tx_ready,
      input  rx_left,
      input  rx_right,
      input  rx_valid
   );
endinterface

// File: rtl/i2s_master_trx.sv
// ---------------------------------------------------------------------------
// i2s_master_trx
// Full-duplex I2S master on the system clock. bclk and lrclk come from an
// internal divider; one stereo pair is serialised per frame from a single
// entry holding register, and one stereo pair is deserialised from sdin.
// Framing is selectable per frame: I2S (MSB one bclk after the lrclk edge)
// or left-justified (MSB on the lrclk edge).
//
// Parameters:
//   data_width  bits per channel word, 2 <= data_width <= slot_width-1
//   slot_width  bclk periods per channel slot (frame = 2*slot_width)
//   bclk_div    clk cycles per bclk half period, >= 2
//
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   fmt            0 = I2S, 1 = left-justified (sampled at each frame start)
//   bus            word-side interface (tx pair + handshake, rx pair + strobe)
//   bclk, lrclk    bit clock, word select (0 = left, 1 = right)
//   sdout, sdin    serial data out / in
//
// Optional build macro I2S_MASTER_TRX_STATUS_EN adds:
//   status_clr     clears tx_underrun
//   tx_underrun    sticky flag, set at every frame start with no pair held
// ---------------------------------------------------------------------------
module i2s_master_trx #(
   parameter int data_width = 24,
   parameter int slot_width = 32,
   parameter int bclk_div   = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fmt,
   i2s_master_trx_if.master bus,
   output logic             bclk,
   output logic             lrclk,
   output logic             sdout,
   input  logic             sdin
`ifdef I2S_MASTER_TRX_STATUS_EN
   ,
   input  logic             status_clr,
   output logic             tx_underrun
`endif
);

   localparam int frame_len = 2 * slot_width;
   localparam int fw        = $clog2(frame_len);
   localparam int cw        = $clog2(bclk_div);

   localparam logic [fw-1:0] f_last   = fw'(frame_len - 1);
   localparam logic [fw-1:0] slot_w   = fw'(slot_width);
   localparam logic [cw-1:0] cnt_last = cw'(bclk_div - 1);

   // Position of a frame bit inside its channel slot.
   function automatic int slot_pos(input logic [fw-1:0] fpos);
      int p;
      p = int'(fpos);
      if (p >= slot_width) p = p - slot_width;
      return p;
   endfunction

   // Word bit carried at slot position s, or -1 for a padding position.
   // I2S delays the MSB by one bclk; left-justified puts it at s=0.
   function automatic int word_idx(input int s, input logic fm);
      int k;
      k = fm ? s : s - 1;
      if (k >= 0 && k < data_width) return data_width - 1 - k;
      return -1;
   endfunction

   logic [cw-1:0]         cnt;
   logic [fw-1:0]         f;
   logic [fw-1:0]         f_next;
   logic                  div_hit;
   logic                  fall;
   logic                  rise;
   logic                  load;
   logic                  full;
   logic                  fmt_r;
   logic                  fmt_use;
   logic [data_width-1:0] hold_l;
   logic [data_width-1:0] hold_r;
   logic [data_width-1:0] tx_l;
   logic [data_width-1:0] tx_r;
   logic [data_width-1:0] left_use;
   logic [data_width-1:0] right_use;
   logic [data_width-1:0] tx_word;
   logic [data_width-1:0] rx_l_sh;
   logic [data_width-1:0] rx_r_sh;
   logic [data_width-1:0] rx_l_nxt;
   logic [data_width-1:0] rx_r_nxt;
   logic                  tx_bit;
   int                    tx_idx;
   int                    rx_idx;

   assign bus.tx_ready = ~full;

   always_comb begin
      div_hit = (cnt == cnt_last);
      // bclk is about to toggle: from 1 that is a fall, from 0 a rise.
      fall    = div_hit & bclk;
      rise    = div_hit & ~bclk;
      f_next  = (f == f_last) ? '0 : f + fw'(1);
      load    = fall & (f_next == '0);

      // On the frame-start edge the new word pair and format take effect
      // immediately, so the f=0 bit already uses them.
      fmt_use   = load ? fmt : fmt_r;
      left_use  = tx_l;
      right_use = tx_r;
      if (load) begin
         left_use  = full ? hold_l : '0;
         right_use = full ? hold_r : '0;
      end

      tx_word = (f_next < slot_w) ? left_use : right_use;
      tx_idx  = word_idx(slot_pos(f_next), fmt_use);
      tx_bit  = 1'b0;
      for (int i = 0; i < data_width; i++) begin
         if (i == tx_idx) tx_bit = tx_word[i];
      end

      // Receive uses the current f and the format latched for this frame;
      // the merged value also feeds the output on the last bit of the frame.
      rx_idx   = word_idx(slot_pos(f), fmt_r);
      rx_l_nxt = rx_l_sh;
      rx_r_nxt = rx_r_sh;
      if (rise) begin
         for (int i = 0; i < data_width; i++) begin
            if (i == rx_idx) begin
               if (f < slot_w) rx_l_nxt[i] = sdin;
               else            rx_r_nxt[i] = sdin;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt          <= '0;
         bclk         <= 1'b0;
         lrclk        <= 1'b1;
         sdout        <= 1'b0;
         f            <= f_last;
         full         <= 1'b0;
         fmt_r        <= 1'b0;
         hold_l       <= '0;
         hold_r       <= '0;
         tx_l         <= '0;
         tx_r         <= '0;
         rx_l_sh      <= '0;
         rx_r_sh      <= '0;
         bus.rx_left  <= '0;
         bus.rx_right <= '0;
         bus.rx_valid <= 1'b0;
      end else begin
         cnt <= div_hit ? '0 : cnt + cw'(1);
         if (div_hit) bclk <= ~bclk;

         if (fall) begin
            f     <= f_next;
            lrclk <= (f_next >= slot_w);
            sdout <= tx_bit;
         end

         if (load) begin
            fmt_r <= fmt;
            tx_l  <= left_use;
            tx_r  <= right_use;
         end

         // Accept only into an empty register; a load only empties a full
         // one, so the two never collide. An accept on an underrun load
         // edge waits for the next frame.
         if (bus.tx_valid && !full) begin
            full   <= 1'b1;
            hold_l <= bus.tx_left;
            hold_r <= bus.tx_right;
         end else if (load) begin
            full <= 1'b0;
         end

         rx_l_sh <= rx_l_nxt;
         rx_r_sh <= rx_r_nxt;

         bus.rx_valid <= 1'b0;
         if (rise && f == f_last) begin
            bus.rx_left  <= rx_l_nxt;
            bus.rx_right <= rx_r_nxt;
            bus.rx_valid <= 1'b1;
         end
      end
   end

`ifdef I2S_MASTER_TRX_STATUS_EN
   // Set has priority over clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_underrun <= 1'b0;
      end else if (load && !full) begin
         tx_underrun <= 1'b1;
      end else if (status_clr) begin
         tx_underrun <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_master_trx.sv
// ---------------------------------------------------------------------------
// tb_i2s_master_trx
// Directed bench for i2s_master_trx with data_width=16, slot_width=32,
// bclk_div=2 and sdout looped back to sdin. Frames are captured bit by bit
// on every bclk fall and compared against hand-computed slot images
// (slot image bit 31 = first bit of the slot).
// ---------------------------------------------------------------------------
module tb_i2s_master_trx;

   logic clk = 1'b0;
   logic reset_n;
   logic fmt;
   logic bclk;
   logic lrclk;
   logic sdout;
   logic sdin;
`ifdef I2S_MASTER_TRX_STATUS_EN
   logic status_clr;
   logic tx_underrun;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   i2s_master_trx_if #(.data_width(16)) bus ();

   i2s_master_trx #(
      .data_width(16),
      .slot_width(32),
      .bclk_div  (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .fmt        (fmt),
      .bus        (bus),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .sdout      (sdout),
      .sdin       (sdin)
`ifdef I2S_MASTER_TRX_STATUS_EN
      ,
      .status_clr (status_clr),
      .tx_underrun(tx_underrun)
`endif
   );

   assign sdin = sdout;

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Returns at the first negedge after a bclk fall.
   task automatic next_fall();
      logic p;
      bit   seen = 0;
      p = bclk;
      for (int n = 0; n < 16 && !seen; n++) begin
         @(negedge clk);
         if (p && !bclk) seen = 1;
         p = bclk;
      end
      if (!seen) check("fall_timeout", 32'd0, 32'd1);
   endtask

   // Returns at the negedge just after the fall that starts a frame (f=0).
   task automatic sync_frame();
      logic lp;
      bit   seen = 0;
      for (int n = 0; n < 80 && !seen; n++) begin
         lp = lrclk;
         next_fall();
         if (lp && !lrclk) seen = 1;
      end
      if (!seen) check("frame_timeout", 32'd0, 32'd1);
   endtask

   // Called at f=0; returns just after the f=63 fall.
   task automatic capture(input string tag, input logic [31:0] exp_l, input logic [31:0] exp_r);
      logic [63:0] d;
      logic [63:0] lr;
      d[63]  = sdout;
      lr[63] = lrclk;
      for (int i = 62; i >= 0; i--) begin
         next_fall();
         d[i]  = sdout;
         lr[i] = lrclk;
      end
      check({tag, "_left"},  d[63:32], exp_l);
      check({tag, "_right"}, d[31:0],  exp_r);
      check({tag, "_lrclk"}, lr[63:32] | ~lr[31:0], 32'd0);
   endtask

   task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
      bit ok = 0;
      for (int n = 0; n < 600 && !ok; n++) begin
         if (bus.tx_ready) ok = 1;
         else @(negedge clk);
      end
      check("send_ready", 32'(ok), 32'd1);
      bus.tx_left  = l;
      bus.tx_right = r;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_r,
                          output int t);
      bit seen = 0;
      t = 0;
      for (int n = 0; n < 16 && !seen; n++) begin
         @(negedge clk);
         if (bus.rx_valid) begin
            seen = 1;
            t    = cyc;
         end
      end
      check({tag, "_rx_seen"},  32'(seen),    32'd1);
      check({tag, "_rx_left"},  bus.rx_left,  exp_l);
      check({tag, "_rx_right"}, bus.rx_right, exp_r);
      @(negedge clk);
      check({tag, "_rx_width"}, bus.rx_valid, 32'd0);
   endtask

   // Divider start-up after reset release: first fall on the 4th edge.
   task automatic release_seq(input string tag, input logic exp_ready);
      @(negedge clk);
      check({tag, "_n1_bclk"},     bclk,         32'd0);
      check({tag, "_n1_rx_valid"}, bus.rx_valid, 32'd0);
      check({tag, "_n1_tx_ready"}, bus.tx_ready, 32'(exp_ready));
      @(negedge clk);
      check({tag, "_n2_bclk"}, bclk, 32'd1);
      @(negedge clk);
      check({tag, "_n3_bclk"},  bclk,  32'd1);
      check({tag, "_n3_lrclk"}, lrclk, 32'd1);
      @(negedge clk);
      check({tag, "_n4_bclk"},  bclk,  32'd0);
      check({tag, "_n4_lrclk"}, lrclk, 32'd0);
      check({tag, "_n4_sdout"}, sdout, 32'd0);
   endtask

   initial begin
      int t5;
      int t6;
      int t1;
      reset_n      = 1'b0;
      fmt          = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_left  = '0;
      bus.tx_right = '0;
`ifdef I2S_MASTER_TRX_STATUS_EN
      status_clr   = 1'b0;
`endif
      repeat (3) @(negedge clk);

      // reset state
      check("rst_bclk",     bclk,         32'd0);
      check("rst_lrclk",    lrclk,        32'd1);
      check("rst_sdout",    sdout,        32'd0);
      check("rst_tx_ready", bus.tx_ready, 32'd1);
      check("rst_rx_valid", bus.rx_valid, 32'd0);
      check("rst_rx_left",  bus.rx_left,  32'd0);
      check("rst_rx_right", bus.rx_right, 32'd0);
`ifdef I2S_MASTER_TRX_STATUS_EN
      check("rst_underrun", tx_underrun,  32'd0);
`endif

      // frame 1: I2S, pair accepted before the first load
      reset_n      = 1'b1;
      bus.tx_left  = 16'hA5C3;
      bus.tx_right = 16'h8001;
      bus.tx_valid = 1'b1;
      release_seq("rel0", 1'b0);
      bus.tx_valid = 1'b0;
      check("f1_ready_after_load", bus.tx_ready, 32'd1);
      capture("f1", 32'h52E1_8000, 32'h4000_8000);
`ifdef I2S_MASTER_TRX_STATUS_EN
      check("f1_underrun", tx_underrun, 32'd0);
`endif
      wait_rx("f1", 16'hA5C3, 16'h8001, t1);

      // frames 2 and 3: underrun, zeros
      sync_frame();
      capture("f2", 32'd0, 32'd0);
`ifdef I2S_MASTER_TRX_STATUS_EN
      check("f2_underrun", tx_underrun, 32'd1);
      status_clr = 1'b1;
      @(negedge clk);
      status_clr = 1'b0;
      check("f2_underrun_clr", tx_underrun, 32'd0);
`endif
      sync_frame();
      capture("f3", 32'd0, 32'd0);
`ifdef I2S_MASTER_TRX_STATUS_EN
      check("f3_underrun", tx_underrun, 32'd1);
`endif

      // frame 4: pair offered exactly on the underrun load edge
      repeat (3) @(negedge clk);
      check("f4_ready_before", bus.tx_ready, 32'd1);
      bus.tx_left  = 16'h1234;
      bus.tx_right = 16'hFEDC;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      check("f4_frame_start", lrclk, 32'd0);
      check("f4_ready_low",   bus.tx_ready, 32'd0);
      capture("f4", 32'd0, 32'd0);
      check("f4_ready_held",  bus.tx_ready, 32'd0);

      // frame 5: left-justified; fmt toggled back mid-frame has no effect
      fmt = 1'b1;
      sync_frame();
      check("f5_ready_after_load", bus.tx_ready, 32'd1);
      fork
         capture("f5", 32'h1234_0000, 32'hFEDC_0000);
         begin
            repeat (80) @(negedge clk);
            fmt = 1'b0;
            send_pair(16'h1234, 16'hFEDC);
         end
      join
      wait_rx("f5", 16'h1234, 16'hFEDC, t5);

      // frame 6: same pair in I2S framing
      sync_frame();
      capture("f6", 32'h091A_0000, 32'h7F6E_0000);
      send_pair(16'hFFFF, 16'hFFFF);
      wait_rx("f6", 16'h1234, 16'hFEDC, t6);
      check("rx_period", 32'(t6 - t5), 32'd256);

      // frame 7: reset mid right slot with a pair still held
      sync_frame();
      send_pair(16'h0F0F, 16'h0F0F);
      check("f7_ready_low", bus.tx_ready, 32'd0);
      repeat (40) next_fall();
      check("f7_sdout_f40", sdout, 32'd1);
      check("f7_lrclk_f40", lrclk, 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("mrst_bclk",     bclk,         32'd0);
      check("mrst_lrclk",    lrclk,        32'd1);
      check("mrst_sdout",    sdout,        32'd0);
      check("mrst_tx_ready", bus.tx_ready, 32'd1);
      check("mrst_rx_valid", bus.rx_valid, 32'd0);
      check("mrst_rx_left",  bus.rx_left,  32'd0);
      check("mrst_rx_right", bus.rx_right, 32'd0);
`ifdef I2S_MASTER_TRX_STATUS_EN
      check("mrst_underrun", tx_underrun,  32'd0);
`endif
      reset_n = 1'b1;
      release_seq("rel1", 1'b1);
      capture("f8", 32'd0, 32'd0);
`ifdef I2S_MASTER_TRX_STATUS_EN
      check("f8_underrun", tx_underrun, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_master_trx.md
Name: i2s_master_trx

Overview:
- Parametrised full-duplex I2S master running on the single system clock.
- Generates bclk and lrclk internally from clk through a divider, serialises a stereo (left/right) word pair taken through a valid/ready handshake, and deserialises a stereo pair from sdin.
- Replaces the separate fixed-width lrclk generator, mono rx and mono-to-stereo tx.
- Adds runtime selection of I2S or left-justified framing.

Parameters:
- data_width, 24: bits per channel word. Must satisfy 2 <= data_width <= slot_width-1.
- slot_width, 32: bclk periods per channel slot. Frame length = 2*slot_width.
- bclk_div, 4: clk cycles per bclk half-period. Must be >= 2.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: synchronous, active-low reset.
- fmt, in, 1: 0 = I2S (MSB one bclk after lrclk edge); 1 = left-justified (MSB on the lrclk edge).
- tx_left, in, data_width: left word to transmit.
- tx_right, in, data_width: right word to transmit.
- tx_valid, in, 1: tx word pair is presented.
- tx_ready, out, 1: holding register is empty.
- rx_left, out, data_width: last received left word.
- rx_right, out, data_width: last received right word.
- rx_valid, out, 1: one-clk pulse; a new rx pair is on rx_left/rx_right.
- bclk, out, 1: bit clock.
- lrclk, out, 1: word select; 0 = left, 1 = right.
- sdout, out, 1: serial data out.
- sdin, in, 1: serial data in.

Behaviour:
- Reset (reset_n low at a clk edge): bclk=0, lrclk=1, sdout=0, tx_ready=1, rx_valid=0, rx_left=0, rx_right=0; divider count=0; frame bit counter f=2*slot_width-1; holding register empty.
- Divider:
  - Count runs 0..bclk_div-1. At bclk_div-1, bclk toggles and the count returns to 0.
  - A toggle 1->0 is a fall strobe; a toggle 0->1 is a rise strobe.
- Fall strobe:
  - f <= (f+1) mod 2*slot_width.
  - lrclk <= (f_next >= slot_width).
  - sdout <= data bit for f_next.
  - All outputs are registered and change on the same clk edge as bclk.
- Slot position s = f_next mod slot_width. Data bit index k:
  - fmt=0: k = s-1, valid for s in 1..data_width.
  - fmt=1: k = s, valid for s in 0..data_width-1.
  - sdout = word[data_width-1-k] when valid, else 0.
  - Left word is used when f_next < slot_width; right word otherwise.
- Frame load happens on a fall strobe with f_next=0:
  - fmt is sampled into a frame-local register. fmt changes mid-frame have no effect until the next load.
  - If the holding register is full, the pair moves to the tx shift registers and the holding register empties (tx_ready rises the next clk).
  - If the holding register is empty (underrun), the frame transmits all zeros.
- Handshake:
  - Accept when tx_valid && tx_ready on a clk edge. tx_ready drops the next clk.
  - An accept in the same cycle as an underrun frame load is not bypassed. The pair is transmitted in the following frame.
  - tx_left/tx_right are don't-care when not accepted.
- Rise strobe:
  - sdin is sampled at the current f, using the same slot/k mapping as tx with the latched fmt.
  - Bits are captured into left/right rx shift registers; non-data bit positions are ignored.
- rx_valid:
  - On the rise strobe at f=2*slot_width-1, rx_left/rx_right update and rx_valid pulses high for exactly one clk on the next cycle.
  - There is no backpressure.
  - The first frame after reset produces an rx pulse containing whatever sdin carried.
- Reset asserted mid-frame: every output returns to its reset value on that edge. The partial tx/rx words are discarded and no rx_valid pulse is produced.
- Steady state: lrclk period = 4*slot_width*bclk_div clk cycles. The first fall strobe after reset occurs at clk cycle 2*bclk_div.

Optional Feature:
- Macro: I2S_MASTER_TRX_STATUS_EN.
- Defined:
  - Adds input status_clr (1 bit) and output tx_underrun (1 bit, reset 0).
  - tx_underrun is set on every underrun frame load and held until a clk with status_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined: both ports are absent. Underrun still transmits zeros silently.

Test Plan:
- Bench parameters for all scenarios: data_width=16, slot_width=32, bclk_div=2.
- fmt=0; accept tx_left=16'hA5C3, tx_right=16'h8001 before the first frame load -> sdout in the left slot = 0, then A5C3 MSB-first on f=1..16, then zeros; right slot carries 8001 on f=33..48; tx_ready returns high 1 clk after the load.
- fmt=1; loop sdout to sdin with tx pair 16'h1234 / 16'hFEDC -> rx_valid pulses once per frame (period 256 clk); rx_left=1234, rx_right=FEDC; sdout MSB coincides with the lrclk edge.
- No tx_valid after reset -> all-zero frames; tx_underrun=1 with the macro; status_clr pulse -> 0; if the next frame also underruns -> 1 again.
- tx_valid presented on the exact frame-load cycle while empty -> that frame is zeros; the pair appears in the next frame; tx_ready stays low until that load.
- Toggle fmt mid-frame -> current frame is unchanged; the new framing starts at the next f=0.
- Drop reset_n mid-right-slot for 1 clk -> bclk=0, lrclk=1, sdout=0, tx_ready=1 next edge; no rx_valid pulse; first fall strobe 4 clk after release.
